pong_motion_engine: RTL and testbench

Ball and paddle motion engine for the Pong game. It sits directly upstream of the top-level game FSM: it consumes debounced keypad controls (`up1`/`down1`/`up2`/`down2`), the FSM's `stop` and the timer's `sec1` digit. It produces ball and paddle coordinates for the graphics generator, plus single-cycle `miss1`/`miss2` events that drive scoring and the new-ball state. All motion advances on an internal motion tick derived from the system clock.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/motion_tick.sv | 16 +
 rtl/pong_motion_engine.sv | 135 +++++++++++++
 tb/tb_pong_motion_engine.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared playfield/object constants, state and direction types, motion helpers
package pong_pkg;
  localparam int C_H_RES       = 640;
  localparam int C_V_RES       = 480;
  localparam int C_BALL_SIZE   = 8;
  localparam int C_PADDLE_H    = 64;
  localparam int C_PADDLE_W    = 8;
  localparam int C_PADDLE1_X   = 16;
  localparam int C_PADDLE2_X   = 616;
  localparam int C_PADDLE_STEP = 4;
  localparam int C_TICK_DIV    = 250000;
  localparam int C_SPEED_MAX   = 4;
  typedef enum logic [1:0] {SERVE, RUN, MISS} state_t;
  typedef enum logic {DIR_POS, DIR_NEG} dir_t;
  // Centre coordinate of an object of a given size along a span
  function automatic int centre(input int span, input int size);
    return (span - size) / 2;
  endfunction
  // One paddle step: up alone moves up, down alone moves down, then clamp to 0..ymax
  function automatic logic [9:0] paddle_next(input logic [9:0] y, input logic up, input logic dn,
                                             input logic signed [10:0] step, input logic signed [10:0] ymax);
    logic signed [10:0] v;
    v = signed'({1'b0, y}) + (up && !dn ? -step : !up && dn ? step : 11'sd0);
    return v < 0 ? 10'd0 : v > ymax ? ymax[9:0] : v[9:0];
  endfunction
endpackage

// File: rtl/motion_tick.sv
// motion_tick: free-running divider giving a one-cycle tick every DIV clocks
module motion_tick #(
  parameter int DIV = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  assign o_tick = r_cnt == W'(DIV - 1);
  // count 0..DIV-1 and wrap on the tick
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/pong_motion_engine.sv
// pong_motion_engine: ball/paddle motion for Pong; speed ramp on sec1 rollover when PONG_SPEEDUP_EN is defined
module pong_motion_engine
  import pong_pkg::*;
#(
  parameter int H_RES       = C_H_RES,
  parameter int V_RES       = C_V_RES,
  parameter int BALL_SIZE   = C_BALL_SIZE,
  parameter int PADDLE_H    = C_PADDLE_H,
  parameter int PADDLE_W    = C_PADDLE_W,
  parameter int PADDLE1_X   = C_PADDLE1_X,
  parameter int PADDLE2_X   = C_PADDLE2_X,
  parameter int PADDLE_STEP = C_PADDLE_STEP,
  parameter int TICK_DIV    = C_TICK_DIV,
  parameter int SPEED_MAX   = C_SPEED_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic       up1,
  input  logic       down1,
  input  logic       up2,
  input  logic       down2,
  input  logic [3:0] sec1,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic       miss1,
  output logic       miss2,
  output logic [2:0] speed
);
  localparam logic signed [10:0] L_CX   = 11'(centre(H_RES, BALL_SIZE));
  localparam logic signed [10:0] L_CY   = 11'(centre(V_RES, BALL_SIZE));
  localparam logic signed [10:0] L_PY0  = 11'(centre(V_RES, PADDLE_H));
  localparam logic signed [10:0] L_PMAX = 11'(V_RES - PADDLE_H);
  localparam logic signed [10:0] L_BMAX = 11'(V_RES - BALL_SIZE);
  localparam logic signed [10:0] L_P1   = 11'(PADDLE1_X + PADDLE_W);
  localparam logic signed [10:0] L_P2   = 11'(PADDLE2_X - BALL_SIZE);
  localparam logic signed [10:0] L_BS   = 11'(BALL_SIZE);
  localparam logic signed [10:0] L_PH   = 11'(PADDLE_H);
  localparam logic signed [10:0] L_STEP = 11'(PADDLE_STEP);
  state_t r_state, w_state_nx;
  dir_t r_dx, r_dy;
  logic [9:0] r_bx, r_by, r_p1, r_p2;
  logic r_miss1, r_miss2;
  logic w_tick, w_go, w_ball_en;
  logic signed [10:0] w_sp, w_bx, w_by, w_nx, w_ny, w_p1, w_p2;
  logic w_ov1, w_ov2, w_edge1, w_edge2, w_hit1, w_hit2, w_miss1, w_miss2, w_miss;
  motion_tick #(.DIV(TICK_DIV)) u_tick (.i_clk(clk), .i_rst_n(rst), .o_tick(w_tick));
  assign w_go    = w_tick & ~stop;
  assign w_sp    = signed'(11'(speed));
  assign w_bx    = signed'({1'b0, r_bx});
  assign w_by    = signed'({1'b0, r_by});
  assign w_p1    = signed'({1'b0, r_p1});
  assign w_p2    = signed'({1'b0, r_p2});
  assign w_nx    = r_dx == DIR_POS ? w_bx + w_sp : w_bx - w_sp;
  assign w_ny    = r_dy == DIR_POS ? w_by + w_sp : w_by - w_sp;
  assign w_ov1   = (w_by + L_BS > w_p1) && (w_by < w_p1 + L_PH);
  assign w_ov2   = (w_by + L_BS > w_p2) && (w_by < w_p2 + L_PH);
  // reaching a paddle plane resolves to either a hit or a miss on that same tick
  assign w_edge1 = w_ball_en && r_dx == DIR_NEG && w_nx <= L_P1;
  assign w_edge2 = w_ball_en && r_dx == DIR_POS && w_nx >= L_P2;
  assign w_hit1  = w_edge1 & w_ov1;
  assign w_hit2  = w_edge2 & w_ov2;
  assign w_miss1 = w_edge1 & ~w_ov1;
  assign w_miss2 = w_edge2 & ~w_ov2;
  assign w_miss  = w_miss1 | w_miss2;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= SERVE;
    else r_state <= w_state_nx;
  // next state: serve on a running tick, miss ends the rally, MISS waits for stop every cycle
  always_comb
    w_state_nx = r_state == SERVE ? (w_go ? RUN : SERVE) :
                 r_state == RUN   ? (w_miss ? MISS : RUN) :
                 (stop ? SERVE : MISS);
  // ball moves on running ticks in SERVE (the serve tick itself) and RUN
  always_comb w_ball_en = w_go && r_state != MISS;
  // ball position and direction: paddle and wall reflections apply together
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_bx <= L_CX[9:0];
      r_by <= L_CY[9:0];
      r_dx <= DIR_POS;
      r_dy <= DIR_POS;
    end else if (w_ball_en) begin
      r_bx <= w_miss ? L_CX[9:0] : w_hit2 ? L_P2[9:0] : w_hit1 ? L_P1[9:0] : w_nx[9:0];
      r_dx <= w_miss2 ? DIR_POS : w_miss1 ? DIR_NEG : w_hit2 ? DIR_NEG : w_hit1 ? DIR_POS : r_dx;
      r_by <= w_miss ? L_CY[9:0] : w_ny <= 0 ? 10'd0 : w_ny >= L_BMAX ? L_BMAX[9:0] : w_ny[9:0];
      r_dy <= w_miss ? DIR_POS : w_ny <= 0 ? DIR_POS : w_ny >= L_BMAX ? DIR_NEG : r_dy;
    end
  // paddles follow their keys on every running tick regardless of state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_p1 <= L_PY0[9:0];
      r_p2 <= L_PY0[9:0];
    end else if (w_go) begin
      r_p1 <= paddle_next(r_p1, up1, down1, L_STEP, L_PMAX);
      r_p2 <= paddle_next(r_p2, up2, down2, L_STEP, L_PMAX);
    end
  // one-cycle miss events
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_miss1 <= 1'b0;
      r_miss2 <= 1'b0;
    end else begin
      r_miss1 <= w_miss1;
      r_miss2 <= w_miss2;
    end
`ifdef PONG_SPEEDUP_EN
  localparam logic [2:0] L_SMAX = 3'(SPEED_MAX);
  logic [3:0] r_sec1;
  logic [2:0] r_speed;
  // speed steps up each time the tens-of-seconds digit rolls to zero during a rally
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sec1  <= 4'd0;
      r_speed <= 3'd1;
    end else begin
      r_sec1  <= sec1;
      r_speed <= (r_state == RUN && sec1 == 4'd0 && r_sec1 != 4'd0 && r_speed < L_SMAX) ? r_speed + 3'd1 : r_speed;
    end
  assign speed = r_speed;
`else
  logic w_unused;
  assign w_unused = ^sec1 ^ (SPEED_MAX != 0);
  assign speed = 3'd1;
`endif
  assign ball_x    = r_bx;
  assign ball_y    = r_by;
  assign paddle1_y = r_p1;
  assign paddle2_y = r_p2;
  assign miss1     = r_miss1;
  assign miss2     = r_miss2;
endmodule

// File: tb/tb_pong_motion_engine.sv
// tb_pong_motion_engine: directed scoreboard bench for pong_motion_engine with TICK_DIV=4
module tb_pong_motion_engine;
  logic clk = 1'b0, rst = 1'b0, stop = 1'b0;
  logic up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
  logic [3:0] sec1 = 4'd0;
  logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
  logic miss1, miss2;
  logic [2:0] speed;
  typedef struct {
    string tag;
    int bx, by, p1, p2, m1, m2, sp;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int ebx, eby, esp;

  pong_motion_engine #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .stop(stop),
    .up1(up1), .down1(down1), .up2(up2), .down2(down2), .sec1(sec1),
    .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .miss1(miss1), .miss2(miss2), .speed(speed)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int bx, input int by, input int p1, input int p2,
                            input int m1, input int m2, input int sp);
    sb.push_back('{tag, bx, by, p1, p2, m1, m2, sp});
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: observed empty queue expected a pending entry");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".ball_x"}, 32'(ball_x), e.bx);
      cmp({e.tag, ".ball_y"}, 32'(ball_y), e.by);
      cmp({e.tag, ".paddle1_y"}, 32'(paddle1_y), e.p1);
      cmp({e.tag, ".paddle2_y"}, 32'(paddle2_y), e.p2);
      cmp({e.tag, ".miss1"}, 32'(miss1), e.m1);
      cmp({e.tag, ".miss2"}, 32'(miss2), e.m2);
      cmp({e.tag, ".speed"}, 32'(speed), e.sp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    cycles(4 * n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 316, 236, 208, 208, 0, 0, 1);
    check_out();
    @(negedge clk) rst = 1'b1;
    expect_out("bottom_wall", 552, 472, 208, 208, 0, 0, 1);
    ticks(236);
    check_out();
    expect_out("after_bounce", 553, 471, 208, 208, 0, 0, 1);
    ticks(1);
    check_out();
    expect_out("before_miss2", 607, 417, 208, 208, 0, 0, 1);
    ticks(54);
    check_out();
    expect_out("miss2_pulse", 316, 236, 208, 208, 0, 1, 1);
    ticks(1);
    check_out();
    expect_out("miss2_end", 316, 236, 208, 208, 0, 0, 1);
    cycles(1);
    check_out();
    cycles(3);
    down2 = 1'b1;
    expect_out("paddle2_bottom", 316, 236, 208, 416, 0, 0, 1);
    ticks(52);
    check_out();
    expect_out("paddle2_clamp", 316, 236, 208, 416, 0, 0, 1);
    ticks(1);
    check_out();
    down2 = 1'b0;
    stop = 1'b1;
    expect_out("miss_to_serve", 316, 236, 208, 416, 0, 0, 1);
    ticks(1);
    check_out();
    stop = 1'b0;
    expect_out("approach_p2", 607, 417, 208, 416, 0, 0, 1);
    ticks(291);
    check_out();
    expect_out("hit_p2", 608, 416, 208, 416, 0, 0, 1);
    ticks(1);
    check_out();
    expect_out("return_p2", 607, 415, 208, 416, 0, 0, 1);
    ticks(1);
    check_out();
    up1 = 1'b1;
    down1 = 1'b1;
    expect_out("both_keys", 597, 405, 208, 416, 0, 0, 1);
    ticks(10);
    check_out();
    down1 = 1'b0;
    stop = 1'b1;
    expect_out("frozen", 597, 405, 208, 416, 0, 0, 1);
    ticks(100);
    check_out();
    stop = 1'b0;
    expect_out("resume", 596, 404, 204, 416, 0, 0, 1);
    ticks(1);
    check_out();
    up1 = 1'b0;
    cycles(1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    expect_out("stop_glitch", 595, 403, 204, 416, 0, 0, 1);
    cycles(2);
    check_out();
    expect_out("top_wall", 192, 0, 204, 416, 0, 0, 1);
    ticks(403);
    check_out();
    expect_out("before_miss1", 25, 167, 204, 416, 0, 0, 1);
    ticks(167);
    check_out();
    expect_out("miss1_pulse", 316, 236, 204, 416, 1, 0, 1);
    ticks(1);
    check_out();
    expect_out("miss1_end", 316, 236, 204, 416, 0, 0, 1);
    cycles(1);
    check_out();
    cycles(3);
    stop = 1'b1;
    ticks(1);
    stop = 1'b0;
    expect_out("serve_left", 315, 237, 204, 416, 0, 0, 1);
    ticks(1);
    check_out();
    ebx = 315;
    eby = 237;
    esp = 1;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      sec1 = 4'd1;
      cycles(1);
      sec1 = 4'd0;
`ifdef PONG_SPEEDUP_EN
      esp = esp < 4 ? esp + 1 : 4;
`endif
      ebx -= esp;
      eby += esp;
      expect_out($sformatf("ramp%0d", i), ebx, eby, 204, 416, 0, 0, esp);
      cycles(2);
      check_out();
    end
    cycles(1);
    rst = 1'b0;
    #2;
    expect_out("async_reset", 316, 236, 208, 208, 0, 0, 1);
    check_out();
    @(negedge clk) rst = 1'b1;
    expect_out("post_reset_serve", 317, 237, 208, 208, 0, 0, 1);
    ticks(1);
    check_out();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
